// File: rtl/q_pipe_pkg.sv
// ============================================================================
// q_pipe_pkg : default geometry and count-width helper for the q_pipe pipeline
// Revision   : 1.0
// ============================================================================
`default_nettype none

package q_pipe_pkg;

  localparam int c_def_width = 8;
  localparam int c_def_depth = 4;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_stage.sv
// ============================================================================
// q_stage  : one pipeline slot (data register, valid bit, ready term)
// Revision : 1.0
// ============================================================================
`default_nettype none

module q_stage
  import q_pipe_pkg::*;
#(
  parameter int WIDTH = c_def_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_rdy_next,
  input  logic             i_valid_prev,
  input  logic [WIDTH-1:0] i_data_prev,
  output logic             o_rdy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A slot can take a word if it is empty or its own word is leaving.
  assign o_rdy   = !r_valid || i_rdy_next;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (o_rdy) begin
      r_valid <= i_valid_prev;
      if (i_valid_prev) begin
        r_data <= i_data_prev;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/q_pipe.sv
// ============================================================================
// q_pipe   : DEPTH-stage req/ack pipeline with bubble collapsing and flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module q_pipe
  import q_pipe_pkg::*;
#(
  parameter  int WIDTH = c_def_width,
  parameter  int DEPTH = c_def_depth,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic          w_accept;
  logic          w_emit;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_rdy;
    logic             w_valid;
    logic             w_rdy_next;
    logic             w_valid_prev;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_data_prev;

    if (i == 0) begin : g_first
      assign w_valid_prev = w_accept;
      assign w_data_prev  = in_data;
    end else begin : g_mid
      assign w_valid_prev = g_stage[i-1].w_valid;
      assign w_data_prev  = g_stage[i-1].w_data;
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_rdy_next = out_ack;
    end else begin : g_link
      assign w_rdy_next = g_stage[i+1].w_rdy;
    end

    q_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .i_rdy_next  (w_rdy_next),
      .i_valid_prev(w_valid_prev),
      .i_data_prev (w_data_prev),
      .o_rdy       (w_rdy),
      .o_valid     (w_valid),
      .o_data      (w_data)
    );
  end

  assign in_ack   = g_stage[0].w_rdy && !rst && !flush;
  assign out_req  = g_stage[DEPTH-1].w_valid;
  assign out_data = g_stage[DEPTH-1].w_data;
  assign w_accept = in_req && in_ack;
  assign w_emit   = out_req && out_ack;

  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_emit) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_accept && w_emit) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Occupancy flags are registered from the next count, not reduced from valids.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

  assign count = r_count;
  assign empty = r_empty;
  assign full  = r_full;

endmodule

`default_nettype wire

// File: tb/tb_q_pipe.sv
// ============================================================================
// tb_q_pipe : directed + random bench for q_pipe against a word/position model
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_q_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  int n_checks = 0;
  int n_errors = 0;

  // Model: words in flight (oldest first) with the stage index each sits in.
  logic [WIDTH-1:0] mq_d[$];
  int               mq_p[$];
  logic [WIDTH-1:0] m_last = '0;

  logic             last_in_ack;
  logic [WIDTH-1:0] obs_q[$];

  q_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_req  (in_req),
    .in_data (in_data),
    .in_ack  (in_ack),
    .out_req (out_req),
    .out_data(out_data),
    .out_ack (out_ack),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_out_req();
    return (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1);
  endfunction

  task automatic model_update(input logic r, input logic f, input logic rq,
                              input logic [WIDTH-1:0] dt, input logic ak);
    bit emit;
    bit acc;
    if (r) begin
      mq_d.delete();
      mq_p.delete();
      m_last = '0;
      return;
    end
    emit = m_out_req() && ak;
    acc  = rq && !f && ((mq_p.size() < DEPTH) || ak);
    if (f) begin
      mq_d.delete();
      mq_p.delete();
      return;
    end
    if (emit) begin
      void'(mq_d.pop_front());
      void'(mq_p.pop_front());
      foreach (mq_p[k]) mq_p[k]++;
    end else begin
      // A word advances whenever some slot ahead of it is free.
      foreach (mq_p[k]) begin
        if ((DEPTH - 1 - mq_p[k]) - k > 0) mq_p[k]++;
      end
    end
    if (acc) begin
      mq_d.push_back(dt);
      mq_p.push_back(0);
    end
    if (m_out_req()) m_last = mq_d[0];
  endtask

  task automatic step(input logic r, input logic f, input logic rq,
                      input logic [WIDTH-1:0] dt, input logic ak);
    @(negedge clk);
    rst = r; flush = f; in_req = rq; in_data = dt; out_ack = ak;
    #1;
    check("in_ack",   32'(in_ack),   32'(!r && !f && ((mq_p.size() < DEPTH) || ak)));
    check("out_req",  32'(out_req),  32'(m_out_req()));
    check("out_data", 32'(out_data), 32'(m_last));
    check("count",    32'(count),    32'(mq_p.size()));
    check("empty",    32'(empty),    32'(mq_p.size() == 0));
    check("full",     32'(full),     32'(mq_p.size() == DEPTH));
    last_in_ack = in_ack;
    if (out_req && ak && !r) obs_q.push_back(out_data);
    model_update(r, f, rq, dt, ak);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w36[6];
    int j;

    rst = 1'b1; flush = 1'b0; in_req = 1'b1; in_data = 8'hA5; out_ack = 1'b0;
    @(posedge clk);
    #1;
    // Reset held with a word on offer: nothing may be accepted.
    step(1, 0, 1, 8'hA5, 0);
    check("r34_in_ack", 32'(last_in_ack), 32'd0);
    check("r34_out_data", 32'(out_data), 32'h00);
    check("r34_empty", 32'(empty), 32'd1);

    // Back-to-back stream with the consumer always ready.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 8'(i), 1);
    check("r35_count", 32'(count), 32'd4);
    check("r35_data", 32'(out_data), 32'h05);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
    check("r35_n", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < obs_q.size(); i++) check("r35_order", 32'(obs_q[i]), 32'(i + 1));

    // Backpressure then release.
    obs_q.delete();
    w36 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    j = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, w36[j], 0);
      if (last_in_ack) j++;
    end
    check("r36_accepted", 32'(j), 32'd4);
    check("r36_full", 32'(full), 32'd1);
    check("r36_in_ack", 32'(last_in_ack), 32'd0);
    step(0, 0, 1, w36[j], 1);
    check("r37_in_ack", 32'(last_in_ack), 32'd1);
    check("r37_count", 32'(count), 32'd4);
    if (last_in_ack) j++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, (j < 6), (j < 6) ? w36[j] : 8'h00, 1);
      if (last_in_ack && j < 6) j++;
    end
    check("r36_n", 32'(obs_q.size()), 32'd6);
    for (int i = 0; i < obs_q.size() && i < 6; i++) check("r36_order", 32'(obs_q[i]), 32'(w36[i]));

    // Flush with a word on offer.
    obs_q.delete();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h30 + 8'(i), 0);
    check("r38_pre", 32'(count), 32'd3);
    step(0, 1, 1, 8'h55, 0);
    check("r38_count", 32'(count), 32'd0);
    check("r38_out_req", 32'(out_req), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 1);
    check("r38_none", 32'(obs_q.size()), 32'd0);

    // Reset in the middle of operation.
    step(0, 0, 1, 8'h41, 0);
    step(0, 0, 1, 8'h42, 0);
    check("r39_pre", 32'(count), 32'd2);
    step(1, 0, 0, 8'h00, 0);
    check("r39_count", 32'(count), 32'd0);
    step(0, 0, 1, 8'h7E, 1);
    check("r39_acc", 32'(last_in_ack), 32'd1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    check("r39_early", 32'(out_req), 32'd0);
    step(0, 0, 0, 8'h00, 1);
    check("r39_out_req", 32'(out_req), 32'd1);
    check("r39_out_data", 32'(out_data), 32'h7E);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 8'($urandom()), ($urandom_range(0, 9) < 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/q_pipe.md
Q_PIPE -- requirements
Module: q_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the data bits per stage; legal range is WIDTH >= 1.
REQ-002 Parameter DEPTH, default 4, sets the number of pipeline stages; legal range is DEPTH >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 flush  input  1  synchronous clear of all stage valid bits.
REQ-006 in_req  input  1  producer has a word on in_data.
REQ-007 in_data  input  WIDTH  producer word.
REQ-008 in_ack  output  1  stage 0 can take a word this cycle (combinational).
REQ-009 out_req  output  1  last stage holds a valid word.
REQ-010 out_data  output  WIDTH  last-stage data register.
REQ-011 out_ack  input  1  consumer takes the word this cycle.
REQ-012 count  output  CW  occupied stages, 0..DEPTH, where CW = clog2(DEPTH+1).
REQ-013 empty / full  output  1 each  empty = (count == 0); full = (count == DEPTH).

Function
REQ-014 Each stage i SHALL hold a data register d[i] and a valid bit v[i].
REQ-015 Stage readiness SHALL be rdy[i] = !v[i] || rdy[i+1], with rdy[DEPTH] = out_ack; this is a combinational chain.
REQ-016 in_ack SHALL be rdy[0] && !rst && !flush.
REQ-017 Accept SHALL occur when in_req && in_ack; emit SHALL occur when out_req && out_ack.
REQ-018 Stage move rule: when rdy[i] is high, v[i] <= v[i-1] (v[-1] = accept) and d[i] <= d[i-1] if v[i-1]; otherwise stage i holds.
REQ-019 With no stall, a word accepted at edge k SHALL appear on out_req/out_data after edge k+DEPTH-1, i.e. DEPTH cycles of latency.
REQ-020 Throughput SHALL be one word per cycle when out_ack stays high, including when the pipeline is full (simultaneous accept and emit).
REQ-021 Words SHALL leave in acceptance order, with no loss or duplication under any in_req/out_ack pattern.
REQ-022 count SHALL update as count + accept - emit each cycle; it SHALL never exceed DEPTH or underflow.
REQ-023 flush SHALL clear every v[i] and count to 0 at the next edge.
REQ-024 During a flush cycle no accept occurs, and any emit in that cycle still counts as taken by the consumer; d[i] contents are retained.
REQ-025 A bubble in stage i SHALL be filled even while downstream stages stall.
REQ-026 out_data SHALL equal d[DEPTH-1] at all times; it is meaningful only while out_req is high.

Reset
REQ-027 rst SHALL take priority over flush and all handshakes.
REQ-028 On reset: all v[i] = 0, all d[i] = 0, out_req = 0, out_data = 0, count = 0, empty = 1, full = 0, in_ack = 0.
REQ-029 A word in flight when rst asserts mid-operation SHALL be discarded.
REQ-030 The first accept after reset is possible in the first cycle with rst low.

Structure
REQ-031 Shared package q_pipe_pkg SHALL hold the default WIDTH/DEPTH constants and the count-width helper function used for CW.
REQ-032 One sub-module, q_stage (one data register, one valid bit, and its rdy logic), SHALL be instantiated DEPTH times via generate.
REQ-033 count, empty and full SHALL be registered in q_pipe, not derived per stage.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset: rst=1 for 2 cycles with in_req=1, in_data=0xA5 -> in_ack=0, out_req=0, out_data=0x00, count=0, empty=1.
REQ-035 Stream: push 0x01..0x08 back-to-back with out_ack=1 -> 0x01 appears 4 cycles after its accept, then one word per cycle in order, count steady at 4.
REQ-036 Backpressure: out_ack=0, offer 0x10..0x15 -> exactly 0x10..0x13 accepted, full=1, in_ack=0; then out_ack=1 -> 0x10..0x13 then 0x14, 0x15, none lost or duplicated.
REQ-037 Full plus drain: pipeline full, in_req=1 and out_ack=1 in the same cycle -> in_ack=1 that cycle and count stays 4.
REQ-038 Flush: count=3 with flush=1 and in_req=1 (0x55) -> next cycle count=0 and out_req=0, 0x55 never emerges.
REQ-039 Mid-operation reset: rst asserted with count=2 -> next cycle count=0, and the first post-reset word 0x7E emerges first after 4 cycles.
